wb_bus_arbiter: RTL and testbench

Two-master to one-slave Wishbone B4 classic-cycle arbiter sitting between the CPU-side bus masters and the shared RAM/device interconnect. Master 0 is instruction fetch and master 1 is the data bus unit (wb_cpu_bus). The arbiter grants the slave port to one master per bus cycle, round-robin on ties. It routes ACK/ERR back to the owner only, and can optionally abort cycles whose slave never acknowledges.

---
 rtl/wb_arb_pkg.sv | 19 +
 rtl/wb_arb_timeout.sv | 42 ++++
 rtl/wb_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM state encoding,
// master indices and the round-robin tie-break helper.
package wb_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_e;

   localparam logic MST_FETCH = 1'b0;
   localparam logic MST_DATA  = 1'b1;

   // On a tie the master that was not served most recently wins.
   function automatic logic pick_tie(input logic last_gnt);
      return ~last_gnt;
   endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Stall watchdog for the granted Wishbone cycle: counts strobed cycles without
// ACK and flags the cycle in which the count has reached TIMEOUT.
module wb_arb_timeout
   import wb_arb_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic active_i,
   input  logic stb_i,
   input  logic ack_i,
   output logic err_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             hit;

   assign hit   = (cnt_q == CNT_W'(TIMEOUT));
   assign err_o = active_i & hit;

   // Counter sits at zero while idle, so every new grant starts from zero.
   always_comb begin
      cnt_d = cnt_q;
      if (!active_i || ack_i) begin
         cnt_d = '0;
      end else if (stb_i && !hit) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master (fetch / data) to one-slave Wishbone B4 classic arbiter with
// round-robin tie-break. Define WB_ARB_TIMEOUT_EN to abort hung slave cycles.
//
// state | meaning
// IDLE  | no owner; slave port and all responses driven 0
// GNT0  | master 0 (fetch) owns the slave port until it drops CYC
// GNT1  | master 1 (data) owns the slave port until it drops CYC
module wb_bus_arbiter
   import wb_arb_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic [31:0] M0_ADR_I,
   input  logic [31:0] M0_DAT_I,
   input  logic [3:0]  M0_SEL_I,
   input  logic        M0_CYC_I,
   input  logic        M0_STB_I,
   input  logic        M0_WE_I,
   output logic [31:0] M0_DAT_O,
   output logic        M0_ACK_O,
   output logic        M0_ERR_O,
   input  logic [31:0] M1_ADR_I,
   input  logic [31:0] M1_DAT_I,
   input  logic [3:0]  M1_SEL_I,
   input  logic        M1_CYC_I,
   input  logic        M1_STB_I,
   input  logic        M1_WE_I,
   output logic [31:0] M1_DAT_O,
   output logic        M1_ACK_O,
   output logic        M1_ERR_O,
   output logic [31:0] ADR_O,
   output logic [31:0] DAT_O,
   output logic [3:0]  SEL_O,
   output logic        CYC_O,
   output logic        STB_O,
   output logic        WE_O,
   input  logic [31:0] DAT_I,
   input  logic        ACK_I
);

   if (TIMEOUT < 1 || TIMEOUT >= (1 << CNT_W)) begin : g_bad_timeout
      $error("wb_bus_arbiter: TIMEOUT must be in 1..2^CNT_W-1");
   end

   arb_state_e state_q;
   arb_state_e state_d;
   logic       last_gnt_q;
   logic       last_gnt_d;
   logic       req0;
   logic       req1;
   logic       err_w;

   assign req0 = M0_CYC_I & M0_STB_I;
   assign req1 = M1_CYC_I & M1_STB_I;

   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      unique case (state_q)
         IDLE: begin
            if (req0 && req1) begin
               if (pick_tie(last_gnt_q) == MST_FETCH) begin
                  state_d    = GNT0;
                  last_gnt_d = MST_FETCH;
               end else begin
                  state_d    = GNT1;
                  last_gnt_d = MST_DATA;
               end
            end else if (req0) begin
               state_d    = GNT0;
               last_gnt_d = MST_FETCH;
            end else if (req1) begin
               state_d    = GNT1;
               last_gnt_d = MST_DATA;
            end
         end
         GNT0: begin
            if (!M0_CYC_I || err_w) state_d = IDLE;
         end
         GNT1: begin
            if (!M1_CYC_I || err_w) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         state_q    <= IDLE;
         last_gnt_q <= MST_DATA;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
      end
   end

   // Slave port and responses depend only on the registered owner, never on
   // the current request lines, so grant changes only take effect at an edge.
   always_comb begin
      ADR_O    = '0;
      DAT_O    = '0;
      SEL_O    = '0;
      CYC_O    = 1'b0;
      STB_O    = 1'b0;
      WE_O     = 1'b0;
      M0_ACK_O = 1'b0;
      M0_ERR_O = 1'b0;
      M1_ACK_O = 1'b0;
      M1_ERR_O = 1'b0;
      unique case (state_q)
         GNT0: begin
            ADR_O    = M0_ADR_I;
            DAT_O    = M0_DAT_I;
            SEL_O    = M0_SEL_I;
            WE_O     = M0_WE_I;
            CYC_O    = M0_CYC_I & ~err_w;
            STB_O    = M0_STB_I & ~err_w;
            M0_ACK_O = ACK_I & ~err_w;
            M0_ERR_O = err_w;
         end
         GNT1: begin
            ADR_O    = M1_ADR_I;
            DAT_O    = M1_DAT_I;
            SEL_O    = M1_SEL_I;
            WE_O     = M1_WE_I;
            CYC_O    = M1_CYC_I & ~err_w;
            STB_O    = M1_STB_I & ~err_w;
            M1_ACK_O = ACK_I & ~err_w;
            M1_ERR_O = err_w;
         end
         default: ;
      endcase
   end

   assign M0_DAT_O = DAT_I;
   assign M1_DAT_O = DAT_I;

`ifdef WB_ARB_TIMEOUT_EN
   logic active_w;

   assign active_w = (state_q == GNT0) || (state_q == GNT1);

   wb_arb_timeout #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_timeout (
      .clk_i    (CLK_I),
      .rst_i    (RST_I),
      .active_i (active_w),
      .stb_i    (STB_O),
      .ack_i    (ACK_I),
      .err_o    (err_w)
   );
`else
   assign err_w = 1'b0;
`endif

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Scoreboard bench for wb_bus_arbiter: directed master sessions push expected
// grants and responses; a monitor pops and compares as the DUT produces them.
module tb_wb_bus_arbiter;

   localparam int TO     = 4;
   localparam int BUDGET = 40;

   logic        CLK_I, RST_I;
   logic [31:0] M0_ADR_I, M0_DAT_I, M1_ADR_I, M1_DAT_I;
   logic [3:0]  M0_SEL_I, M1_SEL_I;
   logic        M0_CYC_I, M0_STB_I, M0_WE_I, M1_CYC_I, M1_STB_I, M1_WE_I;
   logic [31:0] M0_DAT_O, M1_DAT_O;
   logic        M0_ACK_O, M0_ERR_O, M1_ACK_O, M1_ERR_O;
   logic [31:0] ADR_O, DAT_O;
   logic [3:0]  SEL_O;
   logic        CYC_O, STB_O, WE_O;
   logic [31:0] DAT_I;
   logic        ACK_I;

   wb_bus_arbiter #(.TIMEOUT(TO), .CNT_W(8)) dut (
      .CLK_I(CLK_I), .RST_I(RST_I),
      .M0_ADR_I(M0_ADR_I), .M0_DAT_I(M0_DAT_I), .M0_SEL_I(M0_SEL_I),
      .M0_CYC_I(M0_CYC_I), .M0_STB_I(M0_STB_I), .M0_WE_I(M0_WE_I),
      .M0_DAT_O(M0_DAT_O), .M0_ACK_O(M0_ACK_O), .M0_ERR_O(M0_ERR_O),
      .M1_ADR_I(M1_ADR_I), .M1_DAT_I(M1_DAT_I), .M1_SEL_I(M1_SEL_I),
      .M1_CYC_I(M1_CYC_I), .M1_STB_I(M1_STB_I), .M1_WE_I(M1_WE_I),
      .M1_DAT_O(M1_DAT_O), .M1_ACK_O(M1_ACK_O), .M1_ERR_O(M1_ERR_O),
      .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O),
      .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O),
      .DAT_I(DAT_I), .ACK_I(ACK_I)
   );

   initial CLK_I = 1'b0;
   always #5 CLK_I = ~CLK_I;

   typedef struct packed {
      logic        err;
      logic [31:0] adr;
      logic        chk_dat;
      logic [31:0] dat;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   ord_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   int          slv_waits = 0;
   bit          slv_hang  = 0;
   logic [31:0] slv_rdata = 32'h0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s at %0t", name, $time);
   endfunction

   task automatic set_m(input int m, input logic cyc, input logic [31:0] adr,
                        input logic we, input logic [31:0] dat);
      if (m == 0) begin
         M0_CYC_I = cyc; M0_STB_I = cyc; M0_ADR_I = adr; M0_WE_I = we;
         M0_DAT_I = dat; M0_SEL_I = 4'hF;
      end else begin
         M1_CYC_I = cyc; M1_STB_I = cyc; M1_ADR_I = adr; M1_WE_I = we;
         M1_DAT_I = dat; M1_SEL_I = 4'h3;
      end
   endtask

   // One CYC session of n transfers; the address steps by 4 after each ACK.
   task automatic session(input int m, input logic [31:0] adr, input logic we,
                          input logic [31:0] wdat, input int n, input bit lat);
      exp_t e;
      int   got = 0;
      int   k   = 0;
      for (int i = 0; i < n; i++) begin
         e = '{err: 1'b0, adr: adr + 32'(4 * i), chk_dat: ~we, dat: slv_rdata};
         if (m == 0) q0.push_back(e); else q1.push_back(e);
      end
      @(posedge CLK_I); #1;
      set_m(m, 1'b1, adr, we, wdat);
      while (got < n && k < BUDGET) begin
         @(negedge CLK_I);
         if (lat && k == 0) chk("no same-cycle grant", {31'b0, CYC_O}, 32'd0);
         if (lat && k == 1) begin
            chk("grant cyc/stb", {30'b0, CYC_O, STB_O}, 32'd3);
            chk("grant adr", ADR_O, adr);
         end
         if ((m == 0) ? M0_ACK_O : M1_ACK_O) begin
            got++;
            if (got < n) begin
               @(posedge CLK_I); #1;
               set_m(m, 1'b1, adr + 32'(4 * got), we, wdat);
            end
         end
         k++;
      end
      if (got < n) fail_now($sformatf("session m%0d timeout", m));
      @(posedge CLK_I); #1;
      set_m(m, 1'b0, (m == 0) ? M0_ADR_I : M1_ADR_I, 1'b0, 32'h0);
   endtask

   // Slave model: ACK after slv_waits stalled cycles, never when hung.
   initial begin
      int wcnt = 0;
      ACK_I = 1'b0;
      DAT_I = 32'h0;
      forever begin
         @(posedge CLK_I); #2;
         if (CYC_O && STB_O && !slv_hang) begin
            if (wcnt >= slv_waits) begin
               ACK_I = 1'b1; DAT_I = slv_rdata; wcnt = 0;
            end else begin
               ACK_I = 1'b0; DAT_I = 32'h0; wcnt++;
            end
         end else begin
            ACK_I = 1'b0; DAT_I = 32'h0; wcnt = 0;
         end
      end
   end

   // Monitor: grant order on every new CYC_O session, responses on ACK/ERR.
   initial begin
      bit   prev_cyc = 0;
      int   prev_id  = -1;
      int   id;
      exp_t e;
      forever begin
         @(negedge CLK_I);
         if (RST_I) begin
            prev_cyc = 0;
            prev_id  = -1;
         end else begin
            id = !CYC_O ? -1 : (ADR_O == M0_ADR_I) ? 0 : (ADR_O == M1_ADR_I) ? 1 : 2;
            if (CYC_O && !prev_cyc) begin
               if (ord_q.size() == 0) fail_now("unexpected grant");
               else chk("grant order", 32'(id), 32'(ord_q.pop_front()));
            end else if (CYC_O && prev_cyc && id != prev_id) begin
               fail_now("owner switched without idle cycle");
            end
            prev_cyc = CYC_O;
            prev_id  = id;
            if (M0_ACK_O || M0_ERR_O) begin
               if (q0.size() == 0) fail_now("m0 unexpected response");
               else begin
                  e = q0.pop_front();
                  chk("m0 err flag", {31'b0, M0_ERR_O}, {31'b0, e.err});
                  chk("m0 adr", ADR_O, e.adr);
                  if (e.chk_dat) chk("m0 rdata", M0_DAT_O, e.dat);
                  chk("m1 quiet on m0 resp", {30'b0, M1_ACK_O, M1_ERR_O}, 32'd0);
               end
            end
            if (M1_ACK_O || M1_ERR_O) begin
               if (q1.size() == 0) fail_now("m1 unexpected response");
               else begin
                  e = q1.pop_front();
                  chk("m1 err flag", {31'b0, M1_ERR_O}, {31'b0, e.err});
                  chk("m1 adr", ADR_O, e.adr);
                  if (e.chk_dat) chk("m1 rdata", M1_DAT_O, e.dat);
                  chk("m0 quiet on m1 resp", {30'b0, M0_ACK_O, M0_ERR_O}, 32'd0);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int   first;
      int   nerr;
      bit   dropped;
      exp_t e;
      RST_I = 1'b1;
      set_m(0, 1'b0, 32'h0000_2FF0, 1'b0, 32'h0);
      set_m(1, 1'b0, 32'h0000_1FF0, 1'b0, 32'h0);
      repeat (3) @(posedge CLK_I);
      @(negedge CLK_I);
      chk("reset cyc/stb/we", {29'b0, CYC_O, STB_O, WE_O}, 32'd0);
      chk("reset adr", ADR_O, 32'd0);
      chk("reset acks/errs", {28'b0, M0_ACK_O, M0_ERR_O, M1_ACK_O, M1_ERR_O}, 32'd0);
      RST_I = 1'b0;

      // Tie from reset: M0, then M1; then a new tie goes to M0 again.
      slv_waits = 1; slv_rdata = 32'hA5A5_0001;
      ord_q.push_back(0); ord_q.push_back(1);
      fork
         session(0, 32'h0000_2000, 1'b0, 32'h0, 1, 1'b0);
         session(1, 32'h0000_1000, 1'b0, 32'h0, 1, 1'b0);
      join
      repeat (2) @(posedge CLK_I);
      ord_q.push_back(0); ord_q.push_back(1);
      fork
         session(0, 32'h0000_2010, 1'b1, 32'h1111_2222, 1, 1'b0);
         session(1, 32'h0000_1010, 1'b1, 32'h3333_4444, 1, 1'b0);
      join
      repeat (2) @(posedge CLK_I);

      // After M0 alone, a tie must favour M1.
      ord_q.push_back(0);
      session(0, 32'h0000_2020, 1'b0, 32'h0, 1, 1'b0);
      repeat (2) @(posedge CLK_I);
      ord_q.push_back(1); ord_q.push_back(0);
      fork
         session(0, 32'h0000_2030, 1'b0, 32'h0, 1, 1'b0);
         session(1, 32'h0000_1030, 1'b0, 32'h0, 1, 1'b0);
      join
      repeat (2) @(posedge CLK_I);

      // Single M1 read, two wait states.
      slv_waits = 2; slv_rdata = 32'hDEAD_BEEF;
      ord_q.push_back(1);
      session(1, 32'h0000_0100, 1'b0, 32'h0, 1, 1'b1);
      repeat (2) @(posedge CLK_I);

      // Zero-wait slave: ACK arrives in the first granted cycle.
      slv_waits = 0; slv_rdata = 32'h0BAD_F00D;
      ord_q.push_back(0);
      session(0, 32'h0000_2040, 1'b0, 32'h0, 1, 1'b1);
      repeat (2) @(posedge CLK_I);

      // M0 burst of 3 holds the grant while M1 waits.
      ord_q.push_back(0); ord_q.push_back(1);
      fork
         session(0, 32'h0000_2100, 1'b0, 32'h0, 3, 1'b0);
         begin
            repeat (2) @(posedge CLK_I);
            session(1, 32'h0000_1100, 1'b0, 32'h0, 1, 1'b0);
         end
      join
      repeat (2) @(posedge CLK_I);

      // Asynchronous reset in the middle of a GNT1 cycle.
      slv_hang = 1;
      ord_q.push_back(1);
      @(posedge CLK_I); #1;
      set_m(1, 1'b1, 32'h0000_1300, 1'b1, 32'hCAFE_0000);
      repeat (3) @(negedge CLK_I);
      chk("gnt1 before reset", {30'b0, CYC_O, STB_O}, 32'd3);
      #2 RST_I = 1'b1;
      #1;
      chk("reset mid-cycle cyc/stb/we", {29'b0, CYC_O, STB_O, WE_O}, 32'd0);
      chk("reset mid-cycle adr", ADR_O, 32'd0);
      chk("reset mid-cycle dat/sel", {DAT_O[27:0], SEL_O}, 32'd0);
      set_m(1, 1'b0, 32'h0000_1300, 1'b0, 32'h0);
      repeat (2) @(negedge CLK_I);
      RST_I = 1'b0;
      slv_hang = 0; slv_waits = 1; slv_rdata = 32'h5A5A_0002;
      ord_q.push_back(0); ord_q.push_back(1);
      fork
         session(0, 32'h0000_2200, 1'b0, 32'h0, 1, 1'b0);
         session(1, 32'h0000_1200, 1'b0, 32'h0, 1, 1'b0);
      join
      repeat (2) @(posedge CLK_I);

      // Hung slave on an M0 write.
      slv_hang = 1;
      ord_q.push_back(0);
`ifdef WB_ARB_TIMEOUT_EN
      e = '{err: 1'b1, adr: 32'h0000_2400, chk_dat: 1'b0, dat: 32'h0};
      q0.push_back(e);
      @(posedge CLK_I); #1;
      set_m(0, 1'b1, 32'h0000_2400, 1'b1, 32'h7777_8888);
      first = -1; nerr = 0; dropped = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge CLK_I);
         if (M0_ERR_O) begin
            nerr++;
            if (first < 0) begin
               first = k;
               chk("abort forces cyc/stb low", {30'b0, CYC_O, STB_O}, 32'd0);
            end
         end
         if (first >= 0 && k == first + 1) chk("idle after abort", {30'b0, CYC_O, STB_O}, 32'd0);
         if (first >= 0 && !dropped) begin
            @(posedge CLK_I); #1;
            set_m(0, 1'b0, 32'h0000_2400, 1'b0, 32'h0);
            dropped = 1;
         end
      end
      chk("err cycle index", 32'(first), 32'(TO + 1));
      chk("err pulse width", 32'(nerr), 32'd1);
      if (!dropped) begin
         @(posedge CLK_I); #1;
         set_m(0, 1'b0, 32'h0000_2400, 1'b0, 32'h0);
      end
`else
      @(posedge CLK_I); #1;
      set_m(0, 1'b1, 32'h0000_2400, 1'b1, 32'h7777_8888);
      @(negedge CLK_I);
      for (int k = 0; k < 300; k++) begin
         @(negedge CLK_I);
         chk("no err without timeout", {30'b0, M0_ERR_O, M1_ERR_O}, 32'd0);
         chk("grant retained", {30'b0, CYC_O, STB_O}, 32'd3);
      end
      @(posedge CLK_I); #1;
      set_m(0, 1'b0, 32'h0000_2400, 1'b0, 32'h0);
`endif
      slv_hang = 0; slv_waits = 1; slv_rdata = 32'h600D_0003;
      repeat (2) @(posedge CLK_I);
      ord_q.push_back(1);
      session(1, 32'h0000_1400, 1'b0, 32'h0, 1, 1'b1);

      repeat (3) @(negedge CLK_I);
      chk("m0 queue drained", 32'(q0.size()), 32'd0);
      chk("m1 queue drained", 32'(q1.size()), 32'd0);
      chk("grant queue drained", 32'(ord_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
